charmap_video: RTL and testbench
================================

Name: charmap_video

Overview:
- Parametrised character-map video generator; successor to the fixed 8x8 text display path of the test-harness system.
- Owns raster timing, scrolled tile-map fetch, font fetch, colour expansion, optional background colour and a frame interrupt.
- Sits between the CPU bus (register writes) and the external char/colour/font RAMs. Its RGB, sync and blank outputs drive VGA_* directly.

Parameters:
- H_ACTIVE, 320: visible pixels per line.
- H_TOTAL, 400: pixels per line including blanking.
- HS_START / HS_END, 336 / 368: HS asserted for H in [HS_START, HS_END).
- V_ACTIVE, 240: visible lines.
- V_TOTAL, 262: total lines.
- VS_START / VS_END, 244 / 247: VS asserted for V in [VS_START, VS_END).
- CNT_W, 10: width of the H/V counters.
- MAP_COLS_LOG2, 6: map is 2^6 = 64 columns wide; horizontal wrap.
- MAP_ROWS_LOG2, 5: map is 2^5 = 32 rows high; vertical wrap.
- BG_ENABLE, 0: 1 = pixels with font bit 0 output the bg_colour register; 0 = they output black.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: synchronous reset, active low.
- ce_pix, in, 1: pixel enable; at least 2 clk_sys apart.
- reg_wr, in, 1: CPU register write strobe, one clk_sys.
- reg_addr, in, 2: 0 = scroll_x[7:0]; 1 = scroll_x[CNT_W-1:8]; 2 = scroll_y[7:0]; 3 = bg_colour.
- reg_data, in, 8: write data.
- irq_ack, in, 1: clears irq_n.
- irq_n, out, 1: frame interrupt, active low, level.
- map_addr, out, MAP_ROWS_LOG2+MAP_COLS_LOG2: address to the char RAM and the colour RAM.
- map_code, in, 8: char RAM data; valid 1 clk_sys after map_addr.
- map_colour, in, 8: colour RAM data (RRRGGGBB); valid 1 clk_sys after map_addr.
- font_addr, out, 11: {code, fine_y}.
- font_data, in, 8: font row; valid 1 clk_sys after font_addr; bit 7 = leftmost pixel.
- VGA_R / VGA_G / VGA_B, out, 8 each: pixel colour.
- VGA_HS, VGA_VS, out, 1 each: sync, active high.
- VGA_HB, VGA_VB, out, 1 each: blanking, active high.

Behaviour:
- Clocking and reset:
  - One clock, clk_sys.
  - Reset is synchronous, active-low reset_n.
  - On reset: H = V = 0; scroll and shadow registers = 0; bg_colour = 0; irq_n = 1; all VGA outputs = 0; pipeline valid bits cleared.
- Raster counters (all updates on ce_pix only):
  - H increments each ce_pix. When H = H_TOTAL-1, H wraps to 0 and V increments.
  - When V = V_TOTAL-1 and H wraps, V wraps to 0.
- Scroll registers:
  - reg_wr writes the live copy immediately.
  - Shadow copies load from the live copies on the ce_pix where H = 0 and V = V_ACTIVE (vblank start). Mid-frame writes therefore take effect next frame.
  - Registers 1 and 2 are masked to their widths.
- Map address:
  - mx = (H + sx_shadow) mod 2^(MAP_COLS_LOG2+3); my = (V + sy_shadow) mod 2^(MAP_ROWS_LOG2+3).
  - map_addr = {my[top:3], mx[top:3]}, registered on ce_pix.
- Pipeline (advances only on ce_pix; each memory has 1 clk_sys latency, so data is stable by the next ce_pix):
  - S0: map_addr registered.
  - S1: latch map_code, map_colour, fine_x = mx[2:0]; drive font_addr = {code, my[2:0]}.
  - S2: latch font_data; select bit 7-fine_x.
  - S3: register the RGB outputs.
  - HS, VS, HB, VB are delayed through the same 3 stages so they align with pixels.
  - Total latency: 3 ce_pix from counter to VGA output.
- Colour expansion:
  - R = {c[7:5], c[7:5], c[7:6]}; G = {c[4:2], c[4:2], c[4:3]}; B = {c[1:0] repeated 4x}.
  - Font bit 0: bg_colour expanded the same way if BG_ENABLE, else 0.
  - During blanking: RGB = 0.
- Interrupt:
  - irq_n goes 0 on the same ce_pix that loads the shadows.
  - It stays 0 until the clk_sys after irq_ack = 1.
  - If a set event and irq_ack coincide, the set wins.
- Boundaries:
  - Scroll wraps modulo the map size; the right-hand column continues into column 0.
  - Reset mid-frame restarts at H = V = 0 on the next clk_sys.
  - ce_pix held low freezes all state. Register writes are still accepted.

Decomposition:
- Package charmap_pkg holds:
  - register address constants (REG_SCROLL_X_LO, REG_SCROLL_X_HI, REG_SCROLL_Y, REG_BG_COLOUR);
  - the function that expands RRRGGGBB to 24-bit RGB.
- Sub-module charmap_timing:
  - H/V counters, sync and blank generation, vblank-start strobe;
  - parametrised by the timing parameters above.

Test Plan:
- Reset, no scroll, map_code = 0x41 at map_addr 0, colour 0xE0, font row 0 = 0x80 → at the 3rd ce_pix after H = 0, V = 0: VGA_R = 0xFF, G = 0, B = 0; next 7 pixels 0.
- Write scroll_x = 3 mid-frame → map_addr unchanged until vblank start, then at V = 0, H = 0 it selects column 0 with fine_x = 3.
- scroll_x = 511, 64-column map (512 px) → H = 1 fetches column 0; H = 0 fetches column 63, fine_x 7.
- irq: observe irq_n = 0 at V = 240, H = 0; pulse irq_ack → irq_n = 1 next clk_sys. irq_ack on the set cycle → irq_n stays 0.
- BG_ENABLE = 1, bg_colour = 0x03, font row 0x00 → B = 0xFF, R = G = 0 across active video; 0 in blanking.
- Timing: count ce_pix between HS rising edges = 400; HS width 32; VS width 3 lines; HB high for 80 pixels per line.

Source files
------------

// File: rtl/charmap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : charmap_pkg
//  Purpose  : Register map constants and colour expansion for charmap_video.
//  Revision : 1.0 - initial release
// ============================================================================
package charmap_pkg;

    localparam logic [1:0] REG_SCROLL_X_LO = 2'd0;
    localparam logic [1:0] REG_SCROLL_X_HI = 2'd1;
    localparam logic [1:0] REG_SCROLL_Y    = 2'd2;
    localparam logic [1:0] REG_BG_COLOUR   = 2'd3;

    // RRRGGGBB -> 8:8:8 by bit replication so full-scale codes reach 0xFF.
    function automatic logic [23:0] expand_rgb(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6],
                c[4:2], c[4:2], c[4:3],
                {4{c[1:0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/charmap_timing.sv
`default_nettype none
// ============================================================================
//  Module   : charmap_timing
//  Purpose  : Raster H/V counters, sync/blank decode and vblank-start strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module charmap_timing #(
    parameter int H_ACTIVE = 320,
    parameter int H_TOTAL  = 400,
    parameter int HS_START = 336,
    parameter int HS_END   = 368,
    parameter int V_ACTIVE = 240,
    parameter int V_TOTAL  = 262,
    parameter int VS_START = 244,
    parameter int VS_END   = 247,
    parameter int CNT_W    = 10
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ce_pix,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_hb,
    output logic             o_vb,
    output logic             o_vblank_start
);

    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_H_ACTIVE = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_ACTIVE = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_HS_START = CNT_W'(HS_START);
    localparam logic [CNT_W-1:0] C_HS_END   = CNT_W'(HS_END);
    localparam logic [CNT_W-1:0] C_VS_START = CNT_W'(VS_START);
    localparam logic [CNT_W-1:0] C_VS_END   = CNT_W'(VS_END);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (i_ce_pix) begin
            if (r_h == C_H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == C_V_LAST) ? '0 : r_v + C_ONE;
            end else begin
                r_h <= r_h + C_ONE;
            end
        end
    end

    assign o_h            = r_h;
    assign o_v            = r_v;
    assign o_hs           = (r_h >= C_HS_START) && (r_h < C_HS_END);
    assign o_vs           = (r_v >= C_VS_START) && (r_v < C_VS_END);
    assign o_hb           = (r_h >= C_H_ACTIVE);
    assign o_vb           = (r_v >= C_V_ACTIVE);
    assign o_vblank_start = i_ce_pix && (r_h == '0) && (r_v == C_V_ACTIVE);

endmodule
`default_nettype wire

// File: rtl/charmap_video.sv
`default_nettype none
// ============================================================================
//  Module   : charmap_video
//  Purpose  : Scrolled character-map video generator with frame interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module charmap_video
    import charmap_pkg::*;
#(
    parameter int H_ACTIVE      = 320,
    parameter int H_TOTAL       = 400,
    parameter int HS_START      = 336,
    parameter int HS_END        = 368,
    parameter int V_ACTIVE      = 240,
    parameter int V_TOTAL       = 262,
    parameter int VS_START      = 244,
    parameter int VS_END        = 247,
    parameter int CNT_W         = 10,
    parameter int MAP_COLS_LOG2 = 6,
    parameter int MAP_ROWS_LOG2 = 5,
    parameter int BG_ENABLE     = 0
) (
    input  logic                                   clk_sys,
    input  logic                                   reset_n,
    input  logic                                   ce_pix,
    input  logic                                   reg_wr,
    input  logic [1:0]                             reg_addr,
    input  logic [7:0]                             reg_data,
    input  logic                                   irq_ack,
    output logic                                   irq_n,
    output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] map_addr,
    input  logic [7:0]                             map_code,
    input  logic [7:0]                             map_colour,
    output logic [10:0]                            font_addr,
    input  logic [7:0]                             font_data,
    output logic [7:0]                             VGA_R,
    output logic [7:0]                             VGA_G,
    output logic [7:0]                             VGA_B,
    output logic                                   VGA_HS,
    output logic                                   VGA_VS,
    output logic                                   VGA_HB,
    output logic                                   VGA_VB
);

    localparam int MX_W  = MAP_COLS_LOG2 + 3;
    localparam int MY_W  = MAP_ROWS_LOG2 + 3;
    localparam int MAP_W = MAP_ROWS_LOG2 + MAP_COLS_LOG2;

    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    logic             w_hs;
    logic             w_vs;
    logic             w_hb;
    logic             w_vb;
    logic             w_vblank_start;

    charmap_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .HS_START (HS_START),
        .HS_END   (HS_END),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .VS_START (VS_START),
        .VS_END   (VS_END),
        .CNT_W    (CNT_W)
    ) u_timing (
        .i_clk          (clk_sys),
        .i_reset_n      (reset_n),
        .i_ce_pix       (ce_pix),
        .o_h            (w_h),
        .o_v            (w_v),
        .o_hs           (w_hs),
        .o_vs           (w_vs),
        .o_hb           (w_hb),
        .o_vb           (w_vb),
        .o_vblank_start (w_vblank_start)
    );

    logic [CNT_W-1:0] r_scroll_x;
    logic [7:0]       r_scroll_y;
    logic [7:0]       r_bg_colour;
    logic [CNT_W-1:0] r_sx_shadow;
    logic [7:0]       r_sy_shadow;
    logic             r_irq_n;

    // Live registers take CPU writes at any time; the shadows only change at
    // vblank start so a frame is always scanned with one consistent scroll.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_scroll_x  <= '0;
            r_scroll_y  <= '0;
            r_bg_colour <= '0;
            r_sx_shadow <= '0;
            r_sy_shadow <= '0;
            r_irq_n     <= 1'b1;
        end else begin
            if (reg_wr) begin
                case (reg_addr)
                    REG_SCROLL_X_LO: r_scroll_x[7:0]       <= reg_data;
                    REG_SCROLL_X_HI: r_scroll_x[CNT_W-1:8] <= reg_data[CNT_W-9:0];
                    REG_SCROLL_Y:    r_scroll_y            <= reg_data;
                    REG_BG_COLOUR:   r_bg_colour           <= reg_data;
                    default:         ;
                endcase
            end
            if (w_vblank_start) begin
                r_sx_shadow <= r_scroll_x;
                r_sy_shadow <= r_scroll_y;
                r_irq_n     <= 1'b0;
            end else if (irq_ack) begin
                r_irq_n     <= 1'b1;
            end
        end
    end

    logic [CNT_W-1:0] w_mx_sum;
    logic [CNT_W-1:0] w_my_sum;
    logic [MX_W-1:0]  w_mx;
    logic [MY_W-1:0]  w_my;

    assign w_mx_sum = w_h + r_sx_shadow;
    assign w_my_sum = w_v + {{(CNT_W-8){1'b0}}, r_sy_shadow};
    assign w_mx     = w_mx_sum[MX_W-1:0];
    assign w_my     = w_my_sum[MY_W-1:0];

    // Sync/blank travel as {hs, vs, hb, vb} alongside the pixel data.
    logic [MAP_W-1:0] r_map_addr;
    logic [2:0]       r_fx1;
    logic [2:0]       r_fy1;
    logic [3:0]       r_sync1;
    logic             r_valid1;
    logic [10:0]      r_font_addr;
    logic [2:0]       r_fx2;
    logic [7:0]       r_colour2;
    logic [3:0]       r_sync2;
    logic             r_valid2;
    logic [7:0]       r_vga_r;
    logic [7:0]       r_vga_g;
    logic [7:0]       r_vga_b;
    logic [3:0]       r_vga_sync;

    logic             w_font_bit;
    logic             w_active;
    logic [23:0]      w_fg;
    logic [23:0]      w_bg;
    logic [23:0]      w_pix;

    generate
        if (BG_ENABLE != 0) begin : g_bg
            assign w_bg = expand_rgb(r_bg_colour);
        end else begin : g_no_bg
            assign w_bg = '0;
        end
    endgenerate

    assign w_font_bit = font_data[3'd7 - r_fx2];
    assign w_fg       = expand_rgb(r_colour2);
    assign w_active   = r_valid2 && !r_sync2[1] && !r_sync2[0];
    assign w_pix      = !w_active ? 24'd0 : (w_font_bit ? w_fg : w_bg);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_map_addr  <= '0;
            r_fx1       <= '0;
            r_fy1       <= '0;
            r_sync1     <= '0;
            r_valid1    <= 1'b0;
            r_font_addr <= '0;
            r_fx2       <= '0;
            r_colour2   <= '0;
            r_sync2     <= '0;
            r_valid2    <= 1'b0;
            r_vga_r     <= '0;
            r_vga_g     <= '0;
            r_vga_b     <= '0;
            r_vga_sync  <= '0;
        end else if (ce_pix) begin
            r_map_addr  <= {w_my[MY_W-1:3], w_mx[MX_W-1:3]};
            r_fx1       <= w_mx[2:0];
            r_fy1       <= w_my[2:0];
            r_sync1     <= {w_hs, w_vs, w_hb, w_vb};
            r_valid1    <= 1'b1;

            r_font_addr <= {map_code, r_fy1};
            r_fx2       <= r_fx1;
            r_colour2   <= map_colour;
            r_sync2     <= r_sync1;
            r_valid2    <= r_valid1;

            r_vga_r     <= w_pix[23:16];
            r_vga_g     <= w_pix[15:8];
            r_vga_b     <= w_pix[7:0];
            r_vga_sync  <= r_valid2 ? r_sync2 : 4'd0;
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, w_mx_sum[CNT_W-1:MX_W], w_my_sum[CNT_W-1:MY_W], r_bg_colour};

    assign irq_n     = r_irq_n;
    assign map_addr  = r_map_addr;
    assign font_addr = r_font_addr;
    assign VGA_R     = r_vga_r;
    assign VGA_G     = r_vga_g;
    assign VGA_B     = r_vga_b;
    assign VGA_HS    = r_vga_sync[3];
    assign VGA_VS    = r_vga_sync[2];
    assign VGA_HB    = r_vga_sync[1];
    assign VGA_VB    = r_vga_sync[0];

endmodule
`default_nettype wire

// File: tb/tb_charmap_video.sv
`default_nettype none
// ============================================================================
//  Module   : tb_charmap_video
//  Purpose  : Directed checks of charmap_video on a reduced raster (a) and a
//             default raster with background colour enabled (b).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_charmap_video;
    import charmap_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_pix = 1'b0;
    logic        ce_run = 1'b0;
    logic        ce_ph = 1'b0;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        irq_ack;

    logic        a_irq_n, b_irq_n;
    logic [10:0] a_map_addr, b_map_addr;
    logic [7:0]  a_map_code, a_map_colour, b_map_code, b_map_colour;
    logic [10:0] a_font_addr, b_font_addr;
    logic [7:0]  a_font_data, b_font_data;
    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_hb, a_vb, b_hs, b_vs, b_hb, b_vb;

    logic [7:0]  char_ram   [2048];
    logic [7:0]  colour_ram [2048];
    logic [7:0]  font_ram   [2048];

    int checks = 0;
    int errors = 0;
    int npix   = 0;
    int a_hs_cnt = 0, a_vs_cnt = 0, a_hb_cnt = 0;
    int b_hs_cnt = 0, b_hb_cnt = 0;
    int b_rises = 0, b_last_rise = 0, b_period = 0;
    logic b_hs_prev = 1'b0;

    assign b_font_data = 8'h00;

    charmap_video #(
        .H_ACTIVE(32), .H_TOTAL(48), .HS_START(36), .HS_END(40),
        .V_ACTIVE(16), .V_TOTAL(20), .VS_START(17), .VS_END(19),
        .CNT_W(10), .MAP_COLS_LOG2(6), .MAP_ROWS_LOG2(5), .BG_ENABLE(0)
    ) dut (
        .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce_pix),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
        .irq_ack(irq_ack), .irq_n(a_irq_n),
        .map_addr(a_map_addr), .map_code(a_map_code), .map_colour(a_map_colour),
        .font_addr(a_font_addr), .font_data(a_font_data),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_HB(a_hb), .VGA_VB(a_vb)
    );

    charmap_video #(.BG_ENABLE(1)) dut_bg (
        .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce_pix),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
        .irq_ack(irq_ack), .irq_n(b_irq_n),
        .map_addr(b_map_addr), .map_code(b_map_code), .map_colour(b_map_colour),
        .font_addr(b_font_addr), .font_data(b_font_data),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_HB(b_hb), .VGA_VB(b_vb)
    );

    always #5 clk = ~clk;

    // Pixel enable on every second clock, changed away from the active edge.
    always @(negedge clk) begin
        if (ce_run) begin
            ce_ph  = ~ce_ph;
            ce_pix = ce_ph;
        end else begin
            ce_ph  = 1'b0;
            ce_pix = 1'b0;
        end
    end

    // Synchronous RAMs with one clock of read latency.
    always @(posedge clk) begin
        a_map_code   <= char_ram[a_map_addr];
        a_map_colour <= colour_ram[a_map_addr];
        a_font_data  <= font_ram[a_font_addr];
        b_map_code   <= char_ram[b_map_addr];
        b_map_colour <= colour_ram[b_map_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // After step n the video outputs show the pixel of counter value n-3.
    task automatic monitor();
        if (npix >= 3 && npix <= 962) begin
            if (a_hs) a_hs_cnt++;
            if (a_vs) a_vs_cnt++;
            if (a_hb) a_hb_cnt++;
        end
        if (npix >= 3 && npix <= 402) begin
            if (b_hs) b_hs_cnt++;
            if (b_hb) b_hb_cnt++;
        end
        if (npix >= 3 && b_hs && !b_hs_prev && b_rises < 2) begin
            if (b_rises == 1) b_period = npix - b_last_rise;
            b_last_rise = npix;
            b_rises++;
        end
        b_hs_prev = b_hs;
    endtask

    task automatic tick();
        logic hit;
        @(posedge clk);
        hit = ce_pix;
        #1;
        if (hit) begin
            npix++;
            monitor();
        end
    endtask

    task automatic step();
        int start;
        int k;
        start = npix;
        k = 0;
        while (npix == start && k < 8) begin
            tick();
            k++;
        end
        if (npix == start) begin
            checks++;
            errors++;
            $error("FAIL step_timeout observed %0d expected %0d", npix, start + 1);
        end
    endtask

    task automatic run_to(input int target);
        while (npix < target) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_addr = a;
        reg_data = d;
        reg_wr   = 1'b1;
        tick();
        reg_wr   = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        reg_wr   = 1'b0;
        reg_addr = 2'd0;
        reg_data = 8'd0;
        irq_ack  = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            char_ram[i]   = 8'h00;
            colour_ram[i] = 8'h00;
            font_ram[i]   = 8'h00;
        end
        char_ram[0]    = 8'h41; colour_ram[0] = 8'hE0;
        char_ram[1]    = 8'h41; colour_ram[1] = 8'h1C;
        char_ram[63]   = 8'h22;
        font_ram[11'h208] = 8'h80;

        repeat (4) tick();
        chk("rst_irq_n", a_irq_n, 1);
        chk("rst_map_addr", a_map_addr, 0);
        chk("rst_font_addr", a_font_addr, 0);
        chk("rst_rgb", {a_r, a_g, a_b}, 0);
        chk("rst_sync", {a_hs, a_vs, a_hb, a_vb}, 0);
        chk("rst_bg_rgb", {b_r, b_g, b_b}, 0);

        reset_n = 1'b1;
        wr(REG_BG_COLOUR, 8'h03);
        npix = 0;
        ce_run = 1'b1;

        run_to(1);
        chk("first_map_addr", a_map_addr, 0);
        run_to(3);
        chk("pix0_r", a_r, 8'hFF);
        chk("pix0_gb", {a_g, a_b}, 0);
        chk("pix0_blank", {a_hb, a_vb}, 0);
        chk("bg_pix0_b", b_b, 8'hFF);
        chk("bg_pix0_rg", {b_r, b_g}, 0);
        for (int k = 1; k <= 7; k++) begin
            run_to(3 + k);
            chk($sformatf("pix%0d_off", k), {a_r, a_g, a_b}, 0);
        end
        run_to(17);
        chk("col2_map_addr", a_map_addr, 2);

        run_to(112);
        chk("pre_freeze_map_addr", a_map_addr, 1);
        ce_run = 1'b0;
        wr(REG_SCROLL_X_LO, 8'h03);
        repeat (10) tick();
        chk("freeze_map_addr", a_map_addr, 1);
        ce_run = 1'b1;
        run_to(118);
        chk("deferred_scroll", a_map_addr, 2);

        run_to(322);
        chk("bg_pix319_b", b_b, 8'hFF);
        run_to(323);
        chk("bg_pix320_blank", {b_r, b_g, b_b}, 0);

        run_to(768);
        chk("irq_before_vblank", a_irq_n, 1);
        irq_ack = 1'b1;
        run_to(769);
        irq_ack = 1'b0;
        chk("irq_set_wins", a_irq_n, 0);
        tick();
        chk("irq_held", a_irq_n, 0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("irq_acked", a_irq_n, 1);

        run_to(961);
        chk("f2_map_addr_h0", a_map_addr, 0);
        run_to(963);
        chk("a_hs_pixels", a_hs_cnt, 80);
        chk("a_vs_pixels", a_vs_cnt, 96);
        chk("a_hb_pixels", a_hb_cnt, 320);
        chk("b_hs_width", b_hs_cnt, 32);
        chk("b_hb_width", b_hb_cnt, 80);
        chk("b_hs_period", b_period, 400);
        run_to(966);
        chk("f2_map_addr_h5", a_map_addr, 1);
        run_to(967);
        chk("f2_pix4_off", {a_r, a_g, a_b}, 0);
        run_to(968);
        chk("f2_pix5_green", {a_r, a_g, a_b}, 24'h00FF00);

        wr(REG_SCROLL_X_LO, 8'hFF);
        wr(REG_SCROLL_X_HI, 8'h01);
        run_to(1921);
        chk("wrap_map_addr_h0", a_map_addr, 63);
        run_to(1922);
        chk("wrap_map_addr_h1", a_map_addr, 0);
        chk("wrap_font_addr", a_font_addr, 11'h110);
        run_to(1923);
        chk("wrap_pix0_off", {a_r, a_g, a_b}, 0);
        run_to(1924);
        chk("wrap_pix1_red", {a_r, a_g, a_b}, 24'hFF0000);
        chk("irq_frame2", a_irq_n, 0);

        reset_n = 1'b0;
        tick();
        tick();
        chk("midrst_rgb", {a_r, a_g, a_b}, 0);
        chk("midrst_irq_n", a_irq_n, 1);
        chk("midrst_map_addr", a_map_addr, 0);
        reset_n = 1'b1;
        npix = 0;
        run_to(1);
        chk("restart_map_addr", a_map_addr, 0);
        run_to(3);
        chk("restart_pix0", {a_r, a_g, a_b}, 24'hFF0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
